button_conditioner: RTL and testbench

- Upstream input stage for the Space Monsters game logic.
- Takes the four raw board push-buttons (left, right, up, down) and produces, per button:
  - a synchronised, debounced level;
  - a single-cycle press pulse;
  - a press pulse with optional auto-repeat.
- Consumers:
  - the game state machine uses the down press pulse to restart from SUCCESS/FAILED;
  - the block controller uses the left/right levels or repeat pulses for tank movement and the up press pulse for firing.

---
 rtl/button_conditioner_pkg.sv | 28 ++
 rtl/button_conditioner_btn_channel.sv | 130 +++++++++++++
 rtl/button_conditioner.sv | 48 ++++
 tb/tb_button_conditioner.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the Space Monsters button input stage.
//   - rpt_state_t : per-channel auto-repeat state encoding
//   - BTN_*       : board button channel indices
//   - max3        : helper used to size the shared counter width
package button_conditioner_pkg;

  localparam logic [1:0] RPT_IDLE   = 2'd0;
  localparam logic [1:0] RPT_DELAY  = 2'd1;
  localparam logic [1:0] RPT_REPEAT = 2'd2;

  typedef enum logic [1:0] {
    RS_IDLE   = RPT_IDLE,
    RS_DELAY  = RPT_DELAY,
    RS_REPEAT = RPT_REPEAT
  } rpt_state_t;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_conditioner_btn_channel.sv
// One button channel: two-flop synchroniser, debounce counter, press pulse
// and auto-repeat state machine.
//   clk, rst       : clock, async active-high reset
//   i_btn_raw      : raw asynchronous button level
//   o_btn_clean    : debounced level
//   o_btn_pulse    : one-cycle pulse on the debounced press
//   o_btn_repeat   : press pulse plus auto-repeat pulses while held
//
// state     | meaning
// ----------+----------------------------------------------------------
// RS_IDLE   | button released (or repeat disabled); waiting for a press
// RS_DELAY  | held; counting towards the first auto-repeat pulse
// RS_REPEAT | held; emitting a repeat pulse every REPEAT_RATE cycles
module btn_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_raw,
  output logic o_btn_clean,
  output logic o_btn_pulse,
  output logic o_btn_repeat
);

  logic             r_sync1, r_sync2;
  logic             r_clean, r_pulse, r_repeat;
  logic [CNT_W-1:0] r_cnt, r_rcnt;
  rpt_state_t       r_state;

  logic             w_diff, w_term, w_rise;
  rpt_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_rcnt_nxt;
  logic             w_repeat_nxt;

  assign w_diff = (r_sync2 != r_clean);
  assign w_term = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  // The clean level rises on this edge, so the press pulse can be registered
  // alongside it and appear in the very first cycle clean is high.
  assign w_rise = w_term && r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
      // Any cycle that agrees with the clean level restarts the count.
      if (!w_diff || w_term) r_cnt <= '0;
      else                   r_cnt <= r_cnt + CNT_W'(1);
      if (w_term) r_clean <= r_sync2;
      r_pulse <= w_rise;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RS_IDLE;
      r_rcnt   <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rcnt   <= w_rcnt_nxt;
      r_repeat <= w_repeat_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rcnt_nxt   = r_rcnt;
    w_repeat_nxt = 1'b0;
    if (!REPEAT_EN) begin
      w_state_nxt  = RS_IDLE;
      w_rcnt_nxt   = '0;
      w_repeat_nxt = w_rise;
    end else begin
      case (r_state)
        RS_IDLE: begin
          w_rcnt_nxt = '0;
          if (w_rise) begin
            w_state_nxt  = RS_DELAY;
            w_rcnt_nxt   = CNT_W'(1);
            w_repeat_nxt = 1'b1;
          end
        end
        RS_DELAY: begin
          if (!r_clean) begin
            w_state_nxt = RS_IDLE;
            w_rcnt_nxt  = '0;
          end else if (r_rcnt == CNT_W'(REPEAT_DELAY)) begin
            w_state_nxt  = RS_REPEAT;
            w_rcnt_nxt   = CNT_W'(1);
            w_repeat_nxt = 1'b1;
          end else begin
            w_rcnt_nxt = r_rcnt + CNT_W'(1);
          end
        end
        RS_REPEAT: begin
          if (!r_clean) begin
            w_state_nxt = RS_IDLE;
            w_rcnt_nxt  = '0;
          end else if (r_rcnt == CNT_W'(REPEAT_RATE)) begin
            w_rcnt_nxt   = CNT_W'(1);
            w_repeat_nxt = 1'b1;
          end else begin
            w_rcnt_nxt = r_rcnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = RS_IDLE;
          w_rcnt_nxt  = '0;
        end
      endcase
    end
  end

  assign o_btn_clean  = r_clean;
  assign o_btn_pulse  = r_pulse;
  assign o_btn_repeat = r_repeat;

endmodule

// File: rtl/button_conditioner.sv
// Button input stage for the Space Monsters game logic: one conditioning
// channel per board push-button plus an any-button-held flag.
//   clk, rst      : clock, async active-high reset
//   i_btn_raw     : raw asynchronous button levels, active-high
//   o_btn_clean   : debounced levels
//   o_btn_pulse   : one-cycle pulse per debounced press
//   o_btn_repeat  : press pulse plus auto-repeat (channels enabled in REPEAT_MASK)
//   o_any_pressed : OR of the debounced levels
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int               N_BTN           = 4,
  parameter int               DEBOUNCE_CYCLES = 1_000_000,
  parameter int               REPEAT_DELAY    = 25_000_000,
  parameter int               REPEAT_RATE     = 5_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 4'b0011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] i_btn_raw,
  output logic [N_BTN-1:0] o_btn_clean,
  output logic [N_BTN-1:0] o_btn_pulse,
  output logic [N_BTN-1:0] o_btn_repeat,
  output logic             o_any_pressed
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE) + 1);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_EN       (REPEAT_MASK[i]),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .i_btn_raw    (i_btn_raw[i]),
      .o_btn_clean  (o_btn_clean[i]),
      .o_btn_pulse  (o_btn_pulse[i]),
      .o_btn_repeat (o_btn_repeat[i])
    );
  end

  assign o_any_pressed = |o_btn_clean;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
  import button_conditioner_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_btn_raw = 4'b0;
  logic [3:0] o_btn_clean, o_btn_pulse, o_btn_repeat;
  logic       o_any_pressed;

  button_conditioner #(
    .N_BTN           (4),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_RATE     (3),
    .REPEAT_MASK     (4'b0011)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_btn_raw     (i_btn_raw),
    .o_btn_clean   (o_btn_clean),
    .o_btn_pulse   (o_btn_pulse),
    .o_btn_repeat  (o_btn_repeat),
    .o_any_pressed (o_any_pressed)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    int         edge_no;
    logic [3:0] raw;
    logic [3:0] clean;
    logic [3:0] pulse;
    logic [3:0] rep;
    logic       any;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   scen_edge = 0;
  int   base;

  localparam logic [3:0] M_L = 4'b1 << BTN_LEFT;
  localparam logic [3:0] M_R = 4'b1 << BTN_RIGHT;
  localparam logic [3:0] M_U = 4'b1 << BTN_UP;
  localparam logic [3:0] M_D = 4'b1 << BTN_DOWN;

  function automatic void start(input string tag);
    scen_edge = 0;
    base = vecs.size();
  endfunction

  // n edges with the given raw input and expected clean level, no pulses
  function automatic void seg(input string tag, input int n, input logic [3:0] raw,
                              input logic [3:0] clean);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      scen_edge++;
      v.tag = tag; v.edge_no = scen_edge; v.raw = raw; v.clean = clean;
      v.pulse = 4'b0; v.rep = 4'b0; v.any = (clean != 4'b0);
      vecs.push_back(v);
    end
  endfunction

  // mark pulse/repeat expected at scenario edge e (1 = first edge after raw change)
  function automatic void ev(input int e, input logic [3:0] p, input logic [3:0] r);
    vecs[base + e - 1].pulse = vecs[base + e - 1].pulse | p;
    vecs[base + e - 1].rep   = vecs[base + e - 1].rep | r;
  endfunction

  task automatic apply(input vec_t v);
    vec_t e;
    i_btn_raw = v.raw;
    sb.push_back(v);
    @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s edge %0d: scoreboard empty", v.tag, v.edge_no);
    end else begin
      e = sb.pop_front();
      if ({o_btn_clean, o_btn_pulse, o_btn_repeat, o_any_pressed} !==
          {e.clean, e.pulse, e.rep, e.any}) begin
        n_bad++;
        $display("FAIL %s edge %0d: got clean=%b pulse=%b rep=%b any=%b, expected clean=%b pulse=%b rep=%b any=%b",
                 e.tag, e.edge_no, o_btn_clean, o_btn_pulse, o_btn_repeat, o_any_pressed,
                 e.clean, e.pulse, e.rep, e.any);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if ({o_btn_clean, o_btn_pulse, o_btn_repeat, o_any_pressed} !== 13'b0) begin
      n_bad++;
      $display("FAIL %s: got clean=%b pulse=%b rep=%b any=%b, expected all 0",
               tag, o_btn_clean, o_btn_pulse, o_btn_repeat, o_any_pressed);
    end
  endtask

  task automatic apply_hand(input string tag, input int e, input logic [3:0] raw,
                            input logic [3:0] clean, input logic [3:0] pulse,
                            input logic [3:0] rep);
    vec_t v;
    v.tag = tag; v.edge_no = e; v.raw = raw; v.clean = clean;
    v.pulse = pulse; v.rep = rep; v.any = (clean != 4'b0);
    apply(v);
  endtask

  initial begin
    // clean press on UP (no repeat channel), held 30 edges then released
    start("press_up");
    seg("press_up", 5, M_U, 4'b0);
    seg("press_up", 25, M_U, M_U);
    seg("press_up", 5, 4'b0, M_U);
    seg("press_up", 5, 4'b0, 4'b0);
    ev(6, M_U, M_U);

    // 3-cycle glitch on LEFT must be rejected
    start("glitch_left");
    seg("glitch_left", 3, M_L, 4'b0);
    seg("glitch_left", 7, 4'b0, 4'b0);

    // exactly DEBOUNCE_CYCLES-long high on DOWN is accepted
    start("min_down");
    seg("min_down", 4, M_D, 4'b0);
    seg("min_down", 1, 4'b0, 4'b0);
    seg("min_down", 4, 4'b0, M_D);
    seg("min_down", 4, 4'b0, 4'b0);
    ev(6, M_D, M_D);

    // auto-repeat on RIGHT, then release
    start("repeat_right");
    seg("repeat_right", 5, M_R, 4'b0);
    seg("repeat_right", 25, M_R, M_R);
    seg("repeat_right", 5, 4'b0, M_R);
    seg("repeat_right", 7, 4'b0, 4'b0);
    ev(6, M_R, M_R);
    ev(16, 4'b0, M_R); ev(19, 4'b0, M_R); ev(22, 4'b0, M_R);
    ev(25, 4'b0, M_R); ev(28, 4'b0, M_R); ev(31, 4'b0, M_R);
    ev(34, 4'b0, M_R);

    // simultaneous LEFT+DOWN press
    start("simul");
    seg("simul", 5, M_L | M_D, 4'b0);
    seg("simul", 3, M_L | M_D, M_L | M_D);
    seg("simul", 5, 4'b0, M_L | M_D);
    seg("simul", 5, 4'b0, 4'b0);
    ev(6, M_L | M_D, M_L | M_D);

    rst = 1'b1;
    i_btn_raw = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check_zero("after_reset_idle");

    foreach (vecs[k]) apply(vecs[k]);

    // reset while LEFT held: outputs drop at once, press re-detected afterwards
    for (int e = 1; e <= 11; e++)
      apply_hand("rst_hold_pre", e, M_L, (e >= 6) ? M_L : 4'b0,
                 (e == 6) ? M_L : 4'b0, (e == 6) ? M_L : 4'b0);
    #2 rst = 1'b1;
    #1;
    check_zero("rst_async_drop");
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_held");
    #2 rst = 1'b0;
    for (int e = 1; e <= 8; e++)
      apply_hand("rst_hold_post", e, M_L, (e >= 6) ? M_L : 4'b0,
                 (e == 6) ? M_L : 4'b0, (e == 6) ? M_L : 4'b0);

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
